// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : DEPTH-entry in-order FIFO pipeline stage with valid/ready
//                handshakes on both sides, synchronous flush for redirects,
//                occupancy output and a sticky overflow flag.
//  Ports       : clk          - clock, all state updates on the rising edge
//                reset        - asynchronous reset, active low
//                in_valid     - upstream presents in_data
//                in_data      - upstream payload [DATA_W-1:0]
//                in_ready     - buffer accepts in_data this cycle
//                out_valid    - out_data holds the oldest entry
//                out_data     - oldest entry [DATA_W-1:0]
//                out_ready    - downstream consumes out_data this cycle
//                flush        - discard every held entry
//                count        - entries currently held [CNT_W-1:0]
//                overflow_err - sticky: a write was attempted while full
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              overflow_err
);

    // A single-entry buffer still needs a 1-bit pointer to index its array.
    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;

    // Ready/valid come purely from the occupancy register, so a full buffer
    // refuses input even in a cycle where the downstream side pops.
    assign w_in_ready  = (r_count < c_depth);
    assign w_out_valid = (r_count != '0);

    assign w_push = in_valid  & w_in_ready  & ~flush;
    assign w_pop  = out_ready & w_out_valid & ~flush;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= w_wr_ptr_nxt;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_ptr_nxt;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
            // Sticky until reset; a flush cycle never counts as an overflow.
            if (in_valid && !w_in_ready && !flush) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset: uncounted entries are don't-care.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Self-checking bench for pipe_stage_buf. Two instances share
//                the clock and reset: dut0 (DEPTH=2) and dut1 (DEPTH=3, for
//                pointer wrap). A reference model with a per-instance
//                scoreboard queue predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              reset;
    logic              iv    [2];
    logic [DATA_W-1:0] idata [2];
    logic              irdy  [2];
    logic              ovld  [2];
    logic [DATA_W-1:0] odata [2];
    logic              ordy  [2];
    logic              fl    [2];
    logic [CNT_W-1:0]  cnt   [2];
    logic              ovf   [2];

    // reference model state
    logic [DATA_W-1:0] sbq0 [$];
    logic [DATA_W-1:0] sbq1 [$];
    int                m_cnt [2];
    logic              m_ovf [2];
    int                m_dep [2];
    logic              last_acc [2];

    int n_chk;
    int n_pass;

    pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(2), .CNT_W(CNT_W)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(iv[0]), .in_data(idata[0]), .in_ready(irdy[0]),
        .out_valid(ovld[0]), .out_data(odata[0]), .out_ready(ordy[0]),
        .flush(fl[0]), .count(cnt[0]), .overflow_err(ovf[0])
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(3), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(iv[1]), .in_data(idata[1]), .in_ready(irdy[1]),
        .out_valid(ovld[1]), .out_data(odata[1]), .out_ready(ordy[1]),
        .flush(fl[1]), .count(cnt[1]), .overflow_err(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [DATA_W-1:0] sb_front(input int d);
        if (d == 0) return sbq0[0];
        return sbq1[0];
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            m_ovf[d] = 1'b0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    // Compare outputs against the model, advance the model, then clock.
    task automatic tick();
        logic acc, pop;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d count", d), 64'(cnt[d]), 64'(m_cnt[d]));
            chk($sformatf("d%0d in_ready", d), 64'(irdy[d]), 64'(m_cnt[d] < m_dep[d]));
            chk($sformatf("d%0d out_valid", d), 64'(ovld[d]), 64'(m_cnt[d] != 0));
            chk($sformatf("d%0d overflow_err", d), 64'(ovf[d]), 64'(m_ovf[d]));
            if (m_cnt[d] != 0) begin
                chk($sformatf("d%0d out_data", d), 64'(odata[d]), 64'(sb_front(d)));
            end
            acc = iv[d] && (m_cnt[d] < m_dep[d]) && !fl[d];
            pop = ordy[d] && (m_cnt[d] != 0) && !fl[d];
            if (iv[d] && (m_cnt[d] >= m_dep[d]) && !fl[d]) m_ovf[d] = 1'b1;
            last_acc[d] = acc;
            if (fl[d]) begin
                m_cnt[d] = 0;
                if (d == 0) sbq0.delete(); else sbq1.delete();
            end else begin
                if (pop) begin
                    if (d == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
                end
                if (acc) begin
                    if (d == 0) sbq0.push_back(idata[d]); else sbq1.push_back(idata[d]);
                end
                m_cnt[d] = m_cnt[d] + int'(acc) - int'(pop);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic v, input logic [DATA_W-1:0] dat,
                         input logic r, input logic f);
        iv[d]    = v;
        idata[d] = dat;
        ordy[d]  = r;
        fl[d]    = f;
    endtask

    initial begin
        int idx;
        n_chk    = 0;
        n_pass   = 0;
        m_dep[0] = 2;
        m_dep[1] = 3;
        model_clear();
        for (int d = 0; d < 2; d++) drive(d, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset state observed while reset is still asserted
        chk("rst out_valid", 64'(ovld[0]), 64'd0);
        chk("rst in_ready", 64'(irdy[0]), 64'd1);
        reset = 1'b1;
        tick();

        // fill/drain on the 2-deep buffer
        drive(0, 1'b1, 8'h11, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 8'h22, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0); tick(); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();

        // streaming 1..10 with both handshakes held high
        for (int k = 1; k <= 10; k++) begin
            drive(0, 1'b1, 8'(k), 1'b1, 1'b0);
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();

        // full buffer with a concurrent pop refuses the write and flags it
        drive(0, 1'b1, 8'h11, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 8'h22, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 8'h33, 1'b1, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();

        // flush with concurrent push and pop
        drive(0, 1'b1, 8'h55, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 8'h66, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 8'h44, 1'b1, 1'b1); tick();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0); tick(); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0); tick();

        // wrap-around on the 3-deep buffer with random stalls
        idx = 0;
        for (int k = 0; k < 80; k++) begin
            drive(1, (idx < 20) && ($urandom_range(0, 2) != 0), 8'(8'h50 + idx),
                  ($urandom_range(0, 2) == 0), 1'b0);
            tick();
            if (last_acc[1]) idx++;
        end
        chk("wrap all accepted", 64'(idx), 64'd20);
        drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) tick();
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0); tick();

        // asynchronous reset mid-cycle while holding two entries
        drive(0, 1'b1, 8'h77, 1'b0, 1'b0); tick();
        drive(0, 1'b1, 8'h88, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre-reset count", 64'(cnt[0]), 64'd2);
        #3;
        reset = 1'b0;
        #1;
        chk("async out_valid", 64'(ovld[0]), 64'd0);
        chk("async count", 64'(cnt[0]), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
        chk("release in_ready", 64'(irdy[0]), 64'd1);
        chk("release overflow_err", 64'(ovf[0]), 64'd0);
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        // first accept after release lands on the first edge with in_valid
        drive(0, 1'b1, 8'h99, 1'b0, 1'b0); tick();
        drive(0, 1'b0, 8'h00, 1'b1, 1'b0); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width in bits; it is legal for any value of 1 or more.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of buffered entries; it is legal for any value of 1 or more and need not be a power of two.
REQ-003 Parameter CNT_W, default $clog2(DEPTH+1), SHALL set the width of the occupancy output.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  input  1  single clock; every register updates on the rising edge.
- reset  input  1  asynchronous, active-low; asserted at 0, released synchronously to clk by the integrator.
- in_valid  input  1  upstream stage presents in_data.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  buffer accepts in_data this cycle.
- out_valid  output  1  out_data holds the oldest entry.
- out_data  output  DATA_W  oldest entry.
- out_ready  input  1  downstream stage consumes out_data this cycle.
- flush  input  1  discard all entries; used for branch/jump redirect.
- count  output  CNT_W  number of entries currently held.
- overflow_err  output  1  sticky flag for a write attempt while full that was not accepted.

Function
REQ-005 The block SHALL be a DEPTH-entry in-order FIFO pipeline stage built from a circular array with read pointer, write pointer and occupancy counter.
REQ-006 Accept: when in_valid and in_ready are both 1 and flush is 0, the block SHALL write in_data at the write pointer on the clock edge.
REQ-007 Consume: when out_valid and out_ready are both 1 and flush is 0, the block SHALL advance the read pointer.
REQ-008 in_ready SHALL equal (count < DEPTH), driven from registered state only, with no combinational path from out_ready or flush; a full buffer therefore refuses input even in a cycle where it pops.
REQ-009 out_valid SHALL equal (count != 0), and out_data SHALL be the entry at the read pointer, both driven from registered state only.
REQ-010 Latency SHALL be exactly one cycle: data accepted at edge N is visible on out_data/out_valid after edge N when the buffer was empty.
REQ-011 Simultaneous accept and consume SHALL leave count unchanged and move both pointers.
REQ-012 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL never exceed DEPTH and never underflow.
REQ-013 Ordering SHALL be strict FIFO, with no reordering and no duplication.
REQ-014 When flush is 1 at an edge, the block SHALL set count to 0 and both pointers to 0, and SHALL drop any concurrent accept and consume.
REQ-015 Flush SHALL override all handshakes in the same cycle; out_valid SHALL be 0 on the cycle after the flush.
REQ-016 overflow_err SHALL set when in_valid is 1, in_ready is 0 and flush is 0 at an edge; it SHALL clear only on reset.
REQ-017 Entry storage SHALL not require reset; an entry's content is don't-care while the entry is not counted.
REQ-018 When DEPTH is 1, the block SHALL behave as a plain pipeline register that accepts only when empty (half throughput).

Reset
REQ-019 While reset is 0, the block SHALL asynchronously force count=0, both pointers=0, overflow_err=0, and therefore out_valid=0 and in_ready=1.
REQ-020 Reset asserted mid-transfer SHALL discard all held entries, and no entry SHALL appear at the output after release.
REQ-021 The first accept after reset release SHALL take place at the first rising edge where in_valid=1.

Verification
REQ-022 Fill/drain (DEPTH=2, DATA_W=8, out_ready=0): push 0x11 then 0x22 -> count=2, in_ready=0; raise out_ready -> 0x11 then 0x22 on consecutive cycles, then count=0.
REQ-023 Streaming: in_valid=1 and out_ready=1 continuously with values 1,2,3,...,10 -> after a 1-cycle latency, out_data emits 1..10 in order, count stays at 1, and throughput is one per cycle.
REQ-024 Full with pop (count=2, in_valid=1 with 0x33, out_ready=1) -> 0x11 is popped, 0x33 is not accepted, overflow_err=1, and count=1 afterwards.
REQ-025 Flush with concurrent push (count=2, flush=1, in_valid=1 with 0x44, out_ready=1) -> next cycle count=0, out_valid=0, and 0x44 never appears at the output.
REQ-026 Wrap-around (DEPTH=3): 7 push/pop sequences with mixed stalls -> the output order equals the input order and the pointers wrap correctly.
REQ-027 Async reset: assert reset=0 mid-cycle with count=2 -> out_valid=0 immediately without waiting for a clock edge, then in_ready=1 and overflow_err=0 after release.
